mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the 256 x 16 single-port synchronous memory. It shares the memory between an instruction-fetch requester (port 0) and a load/store requester (port 1) using round-robin arbitration. Each accepted request becomes exactly one memory access and one response. It sits between the CPU front end / execute stage and the memory, and owns every memory control input.

## Interface
Parameters:
- ADDR_W, 8: memory address width (256 words).
- DATA_W, 16: memory data width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when ready && valid.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_W  word address.
- req0_wdata / req1_wdata  in  DATA_W  write data.
- rsp0_valid / rsp1_valid  out  1  one-cycle response strobe.
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data; for writes, the previous word content.
- mem_we  out  1  to memory write enable.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write data.
- mem_read_data  in  DATA_W  from memory registered read data.

## Operation
- FSM states:
  - IDLE: accept one request.
  - ACCESS: memory inputs driven.
  - RESP: memory output valid.
- Transitions:
  - IDLE -> ACCESS on handshake.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- reqX_ready is high only in IDLE, and only for the arbitration winner. It is never high on both ports in the same cycle.
- Arbitration:
  - Only one port valid: that port wins.
  - Both valid: the port not granted last wins.
  - last_grant updates only on handshake.
  - last_grant resets to 1, so port 0 wins the first tie.
- Requesters hold valid and payload stable until the handshake. A valid dropped before the handshake is legal; that request is simply not taken.
- On handshake, register we/addr/wdata and the granted port index into mem_we/mem_address/mem_write_data and an internal owner register.
- mem_we is high for exactly the ACCESS cycle, and only for writes. It is cleared entering RESP.
- mem_address and mem_write_data hold their last value until the next handshake.
- In RESP:
  - The owner's rspX_valid = 1.
  - rspX_rdata = mem_read_data. Because the memory is read-before-write, a write returns the old content.
  - rdata for the non-owner port is held, not meaningful.
- A new request arriving during ACCESS/RESP waits (ready low) until IDLE.
- Reset values: reqX_ready 0, rspX_valid 0, rspX_rdata 0, mem_we 0, mem_address 0, mem_write_data 0, state IDLE, last_grant 1.
- Reset asserted mid-transaction:
  - All outputs are forced to reset values immediately (asynchronous).
  - The in-flight request produces no response.
  - A write whose ACCESS edge was not reached is not performed.

## Timing
- Cycle n: reqX_valid && reqX_ready (handshake edge at end of n).
- Cycle n+1: ACCESS. Memory samples mem_* at the end of n+1.
- Cycle n+2: RESP. rspX_valid = 1, rdata valid.
- Cycle n+3: IDLE. The next handshake is possible.
- Latency: 2 cycles from handshake to response. Peak throughput: 1 access per 3 cycles.
- Ready is combinational from state, last_grant and both valids. No combinational path from mem_read_data to any ready.
- Responses are returned in acceptance order. At most one transaction is in flight.

## Structure
- Package mem_arb_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - Default ADDR_W/DATA_W.
  - Port index constants PORT_FETCH=0, PORT_LSU=1.
- Sub-module rr_arbiter2: a 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, enable.
  - Output: one-hot grant.
  - Purely combinational. last_grant is stored in mem_arbiter.
- FSM, command registers and response steering live in mem_arbiter.

## Test plan
- Port 0 alone writes 0xBEEF to 0x10, then reads 0x10:
  - Write response has rdata equal to the prior content.
  - Read response has rdata 0xBEEF, with rsp0_valid 2 cycles after each handshake.
  - rsp1_valid stays 0 throughout.
- Both ports hold valid continuously, both reading from 0x01/0x02:
  - Grants alternate 0,1,0,1.
  - A handshake occurs every 3 cycles.
  - Each response goes to the correct port with the correct word.
- Port 1 writes 0x1234 to 0xFF while port 0 waits:
  - mem_we is high exactly one cycle, with mem_address 0xFF.
  - A later port-0 read of 0xFF returns 0x1234.
- Request asserted during ACCESS:
  - reqX_ready stays low until IDLE.
  - The request is accepted at cycle n+3, and its payload is unchanged at acceptance.
- rst_n pulled low during the ACCESS cycle of a write to 0x20:
  - All outputs are 0 immediately, and no response is produced.
  - After release, a read of 0x20 returns the old value.
  - Port 0 wins the first tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   arb_state_e  : sequencer states (IDLE accepts, ACCESS drives memory,
//                  RESP returns the registered memory word)
//   DEF_ADDR_W   : default word-address width (256-word memory)
//   DEF_DATA_W   : default memory data width
//   PORT_FETCH   : port index of the instruction-fetch requester
//   PORT_LSU     : port index of the load/store requester
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker, purely combinational.
//   req_i        : request vector, bit N = port N valid
//   last_grant_i : port granted by the previous accepted request
//   enable_i     : grants are only issued while enabled
//   grant_o      : one-hot grant (or zero when disabled / no request)
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            // On a tie port 0 wins only if port 1 was served last.
            if (req_i[0] && (!req_i[1] || last_grant_i)) begin
                grant_o = 2'b01;
            end else if (req_i[1]) begin
                grant_o = 2'b10;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous memory
// with registered, read-before-write read data. One transaction in flight;
// each accepted request takes IDLE -> ACCESS -> RESP (3 cycles).
//   clk, rst_n              : clock, asynchronous active-low reset
//   reqN_valid/ready        : request handshake, port 0 = fetch, 1 = LSU
//   reqN_we/addr/wdata      : request payload
//   rspN_valid/rdata        : one-cycle response strobe and returned word
//   mem_we/address/write_data : memory command, registered
//   mem_read_data           : registered memory read data
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    arb_state_e        state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [1:0]        grant;
    logic              handshake;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    // Gating with rst_n keeps ready low while reset is held, even though
    // the state register already reads IDLE.
    rr_arbiter2 u_rr (
        .req_i        ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .enable_i     (rst_n && (state_q == IDLE)),
        .grant_o      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign handshake  = |grant;

    assign we_d    = grant[1] ? req1_we    : req0_we;
    assign addr_d  = grant[1] ? req1_addr  : req0_addr;
    assign wdata_d = grant[1] ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_LSU;
            owner_q      <= PORT_FETCH;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q      <= ACCESS;
                        last_grant_q <= grant[1];
                        owner_q      <= grant[1];
                        mem_we_q     <= we_d;
                        mem_addr_q   <= addr_d;
                        mem_wdata_q  <= wdata_d;
                    end
                end
                ACCESS: begin
                    state_q      <= RESP;
                    mem_we_q     <= 1'b0;
                    rsp0_valid_q <= (owner_q == PORT_FETCH);
                    rsp1_valid_q <= (owner_q == PORT_LSU);
                end
                RESP: begin
                    state_q      <= IDLE;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    // Keep the returned word on the owner's rdata afterwards.
                    if (owner_q == PORT_FETCH) begin
                        rdata0_q <= mem_read_data;
                    end else begin
                        rdata1_q <= mem_read_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we         = mem_we_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign rsp0_valid     = rsp0_valid_q;
    assign rsp1_valid     = rsp1_valid_q;

    // The memory's read register is only valid during RESP, so the owner
    // sees it directly in that cycle and the held copy otherwise.
    assign rsp0_rdata = rsp0_valid_q ? mem_read_data : rdata0_q;
    assign rsp1_rdata = rsp1_valid_q ? mem_read_data : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 256x16
// read-before-write memory and a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    logic [DW-1:0] mem [256];
    bit            mem_loaded = 1'b0;
    logic [DW-1:0] ref_mem [256];
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            model_last = 1'b1;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_we        (req0_we),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_we        (req1_we),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .rsp0_valid     (rsp0_valid),
        .rsp0_rdata     (rsp0_rdata),
        .rsp1_valid     (rsp1_valid),
        .rsp1_rdata     (rsp1_rdata),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 257) ^ 16'hA5C3;
    endfunction

    // Memory: registered read of the old word, write at the same edge.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            mem_read_data <= mem[mem_address];
            if (mem_we) mem[mem_address] <= mem_write_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    endtask

    // Reference: an accepted access returns the current word, then a write
    // replaces it; the accepted port becomes the last grant.
    task automatic model_accept(input bit port, input bit we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, output logic [DW-1:0] exp);
        exp = ref_mem[addr];
        if (we) ref_mem[addr] = wdata;
        model_last = port;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_reqs();
        req0_valid = 1; req1_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we});
        end
        n_tests++;
        if (rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want 0000/0000", rsp0_rdata, rsp1_rdata);
        end
        n_tests++;
        if (mem_address !== '0 || mem_write_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_cmd: got %h/%h want 00/0000", mem_address, mem_write_data);
        end
        clear_reqs();
        tick();
        rst_n = 1;
        model_last = 1;
        tick();
    endtask

    task automatic test_alternate();
        logic [DW-1:0] e;
        bit win;
        bit owner;
        owner = 0; e = '0;
        req0_valid = 1; req0_we = 0; req0_addr = 8'h01;
        req1_valid = 1; req1_we = 0; req1_addr = 8'h02;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                win = !model_last;
                n_tests++;
                if ({req1_ready, req0_ready} !== (win ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL alt_grant k=%0d: got %b want %b", k, {req1_ready, req0_ready}, win ? 2'b10 : 2'b01);
                end
                model_accept(win, 1'b0, win ? 8'h02 : 8'h01, '0, e);
                owner = win;
            end else begin
                n_tests++;
                if ({req1_ready, req0_ready} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL alt_busy_ready k=%0d: got %b want 00", k, {req1_ready, req0_ready});
                end
            end
            if (k % 3 == 2) begin
                n_tests++;
                if ({rsp1_valid, rsp0_valid} !== (owner ? 2'b10 : 2'b01) ||
                    (owner ? rsp1_rdata : rsp0_rdata) !== e) begin
                    n_fail++;
                    $display("FAIL alt_rsp k=%0d: got v=%b d=%h want v=%b d=%h", k, {rsp1_valid, rsp0_valid},
                             owner ? rsp1_rdata : rsp0_rdata, owner ? 2'b10 : 2'b01, e);
                end
            end
            tick();
        end
        clear_reqs();
    endtask

    task automatic test_single_port();
        logic [DW-1:0] e;
        req0_valid = 1; req0_we = 1; req0_addr = 8'h10; req0_wdata = 16'hBEEF;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL sp_wr_grant: got %b want 01", {req1_ready, req0_ready});
        end
        model_accept(0, 1, 8'h10, 16'hBEEF, e);
        tick();
        clear_reqs();
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b1 || mem_address !== 8'h10 || mem_write_data !== 16'hBEEF || rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sp_wr_access: got we=%b a=%h d=%h v=%b want 1/10/beef/0", mem_we, mem_address, mem_write_data, rsp0_valid);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== e || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sp_wr_rsp: got v=%b%b d=%h we=%b want 10 d=%h we=0", rsp0_valid, rsp1_valid, rsp0_rdata, mem_we, e);
        end
        tick();
        req0_valid = 1; req0_we = 0; req0_addr = 8'h10; req0_wdata = '0;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01 || rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sp_rd_grant: got %b v=%b want 01 v=0", {req1_ready, req0_ready}, rsp0_valid);
        end
        model_accept(0, 0, 8'h10, '0, e);
        tick();
        clear_reqs();
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sp_rd_access: got we=%b v=%b%b want 0 00", mem_we, rsp0_valid, rsp1_valid);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== 16'hBEEF || rsp0_rdata !== e) begin
            n_fail++;
            $display("FAIL sp_rd_rsp: got v=%b%b d=%h want 10 d=beef", rsp0_valid, rsp1_valid, rsp0_rdata);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sp_rsp_one_cycle: got %b%b want 00", rsp0_valid, rsp1_valid);
        end
    endtask

    // Last grant is port 0 here, so on the tie port 1 wins and port 0 waits.
    task automatic test_lsu_write();
        logic [DW-1:0] e0, e1;
        int we_count;
        we_count = 0; e0 = '0; e1 = '0;
        tick();
        req0_valid = 1; req0_we = 0; req0_addr = 8'hFF; req0_wdata = '0;
        req1_valid = 1; req1_we = 1; req1_addr = 8'hFF; req1_wdata = 16'h1234;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                we_count++;
                n_tests++;
                if (mem_address !== 8'hFF || k != 1) begin
                    n_fail++;
                    $display("FAIL lsu_we_addr k=%0d: got a=%h want a=ff at k=1", k, mem_address);
                end
            end
            if (k == 0) begin
                n_tests++;
                if ({req1_ready, req0_ready} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL lsu_grant: got %b want 10", {req1_ready, req0_ready});
                end
                model_accept(1, 1, 8'hFF, 16'h1234, e1);
            end
            if (k == 2) begin
                n_tests++;
                if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_rdata !== e1) begin
                    n_fail++;
                    $display("FAIL lsu_wr_rsp: got v=%b%b d=%h want 10 d=%h", rsp1_valid, rsp0_valid, rsp1_rdata, e1);
                end
            end
            if (k == 3) begin
                n_tests++;
                if ({req1_ready, req0_ready} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL lsu_waiter_grant: got %b want 01", {req1_ready, req0_ready});
                end
                model_accept(0, 0, 8'hFF, '0, e0);
            end
            if (k == 5) begin
                n_tests++;
                if (rsp0_valid !== 1'b1 || rsp0_rdata !== 16'h1234 || rsp0_rdata !== e0) begin
                    n_fail++;
                    $display("FAIL lsu_readback: got v=%b d=%h want 1 d=1234", rsp0_valid, rsp0_rdata);
                end
            end
            tick();
            if (k == 0) req1_valid = 0;
            if (k == 3) req0_valid = 0;
        end
        n_tests++;
        if (we_count != 1) begin
            n_fail++;
            $display("FAIL lsu_we_cycles: got %0d want 1", we_count);
        end
        clear_reqs();
    endtask

    task automatic test_wait_during_access();
        logic [DW-1:0] e0, e1, wd;
        wd = DW'($urandom);
        req0_valid = 1; req0_we = 0; req0_addr = 8'h30;
        @(negedge clk);
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_first_grant: got %b want 1", req0_ready);
        end
        model_accept(0, 0, 8'h30, '0, e0);
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_we = 1; req1_addr = 8'h40; req1_wdata = wd;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (req1_ready !== (k == 3)) begin
                n_fail++;
                $display("FAIL wait_ready k=%0d: got %b want %b", k, req1_ready, k == 3);
            end
            if (k == 2) begin
                n_tests++;
                if (rsp0_valid !== 1'b1 || rsp0_rdata !== e0) begin
                    n_fail++;
                    $display("FAIL wait_first_rsp: got v=%b d=%h want 1 d=%h", rsp0_valid, rsp0_rdata, e0);
                end
            end
            if (k < 3) tick();
        end
        model_accept(1, 1, 8'h40, wd, e1);
        tick();
        req1_valid = 0;
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b1 || mem_address !== 8'h40 || mem_write_data !== wd) begin
            n_fail++;
            $display("FAIL wait_payload: got we=%b a=%h d=%h want 1/40/%h", mem_we, mem_address, mem_write_data, wd);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== e1) begin
            n_fail++;
            $display("FAIL wait_second_rsp: got v=%b d=%h want 1 d=%h", rsp1_valid, rsp1_rdata, e1);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e;
        req0_valid = 1; req0_we = 1; req0_addr = 8'h20; req0_wdata = 16'hDEAD;
        @(negedge clk);
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_grant: got %b want 1", req0_ready);
        end
        tick();
        clear_reqs();
        #2;
        rst_n = 0;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we} !== 5'b0 ||
            mem_address !== '0 || mem_write_data !== '0 || rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
            n_fail++;
            $display("FAIL rm_async_clear: got ctl=%b a=%h d=%h r=%h/%h want all zero",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we}, mem_address, mem_write_data, rsp0_rdata, rsp1_rdata);
        end
        model_last = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            n_tests++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rm_no_rsp k=%0d: got %b%b want 00", k, rsp0_valid, rsp1_valid);
            end
        end
        tick();
        rst_n = 1;
        tick();
        req0_valid = 1; req0_we = 0; req0_addr = 8'h20;
        req1_valid = 1; req1_we = 0; req1_addr = 8'h21;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rm_first_tie: got %b want 01", {req1_ready, req0_ready});
        end
        model_accept(0, 0, 8'h20, '0, e);
        tick();
        clear_reqs();
        tick();
        @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== init_word(8'h20) || rsp0_rdata !== e) begin
            n_fail++;
            $display("FAIL rm_old_value: got v=%b d=%h want 1 d=%h", rsp0_valid, rsp0_rdata, init_word(8'h20));
        end
        tick();
    endtask

    task automatic test_random();
        bit            p_v [2];
        bit            p_we [2];
        logic [AW-1:0] p_addr [2];
        logic [DW-1:0] p_wd [2];
        int            age;
        bit            owner, owner_we;
        logic [AW-1:0] owner_addr;
        logic [DW-1:0] owner_wd, owner_exp;
        logic [1:0]    exp_grant, exp_rv;
        age = 99; owner = 0; owner_we = 0; owner_addr = '0; owner_wd = '0; owner_exp = '0;
        for (int p = 0; p < 2; p++) begin
            p_v[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_wd[p] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_v[p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        p_v[p]    = 1;
                        p_we[p]   = 1'($urandom_range(0, 1));
                        p_addr[p] = AW'($urandom_range(0, 15));
                        p_wd[p]   = DW'($urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    p_v[p] = 0;
                end
            end
            req0_valid = p_v[0]; req0_we = p_we[0]; req0_addr = p_addr[0]; req0_wdata = p_wd[0];
            req1_valid = p_v[1]; req1_we = p_we[1]; req1_addr = p_addr[1]; req1_wdata = p_wd[1];
            @(negedge clk);
            exp_grant = 2'b00;
            if (age >= 3) begin
                if (p_v[0] && p_v[1]) exp_grant = model_last ? 2'b01 : 2'b10;
                else if (p_v[0])      exp_grant = 2'b01;
                else if (p_v[1])      exp_grant = 2'b10;
            end
            n_tests++;
            if ({req1_ready, req0_ready} !== exp_grant) begin
                n_fail++;
                $display("FAIL rnd_ready c=%0d: got %b want %b", c, {req1_ready, req0_ready}, exp_grant);
            end
            n_tests++;
            if (mem_we !== (age == 1 && owner_we)) begin
                n_fail++;
                $display("FAIL rnd_mem_we c=%0d: got %b want %b", c, mem_we, age == 1 && owner_we);
            end
            if (age == 1) begin
                n_tests++;
                if (mem_address !== owner_addr || mem_write_data !== owner_wd) begin
                    n_fail++;
                    $display("FAIL rnd_mem_cmd c=%0d: got %h/%h want %h/%h", c, mem_address, mem_write_data, owner_addr, owner_wd);
                end
            end
            exp_rv = (age == 2) ? (owner ? 2'b10 : 2'b01) : 2'b00;
            n_tests++;
            if ({rsp1_valid, rsp0_valid} !== exp_rv) begin
                n_fail++;
                $display("FAIL rnd_rsp_valid c=%0d: got %b want %b", c, {rsp1_valid, rsp0_valid}, exp_rv);
            end
            if (age == 2) begin
                n_tests++;
                if ((owner ? rsp1_rdata : rsp0_rdata) !== owner_exp) begin
                    n_fail++;
                    $display("FAIL rnd_rdata c=%0d: got %h want %h", c, owner ? rsp1_rdata : rsp0_rdata, owner_exp);
                end
            end
            if (exp_grant != 2'b00) begin
                owner      = exp_grant[1];
                owner_we   = p_we[owner];
                owner_addr = p_addr[owner];
                owner_wd   = p_wd[owner];
                model_accept(owner, owner_we, owner_addr, owner_wd, owner_exp);
                p_v[owner] = 0;
                age = 0;
            end
            if (age < 99) age++;
            tick();
        end
        clear_reqs();
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        clear_reqs();
        test_reset();
        test_alternate();
        test_single_port();
        test_lsu_write();
        test_wait_during_access();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
